// File: rtl/aes_dec_seq.sv
// Iterative AES-128 decryption core. RPC inverse rounds are chained per clock,
// so a block takes NR/RPC RUN clocks. Round keys arrive from an external
// supplier indexed by rk_idx; there is no on-chip key schedule.
// Optional build macro AES_DEC_ABORT_EN adds an abort input that cancels a run.
module aes_dec_seq #(
  parameter int unsigned RPC = 2,
  localparam int unsigned NR = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
`ifdef AES_DEC_ABORT_EN
  input  logic                          abort,
`endif
  input  logic [127:0]                  ct_in,
  input  logic [128*RPC-1:0]            rk_in,
  input  logic [127:0]                  rk_final,
  output logic [$clog2(NR/RPC+1)-1:0]   rk_idx,
  output logic                          busy,
  output logic                          done,
  output logic [127:0]                  pt_out
);

  localparam int unsigned NCyc = NR / RPC;
  localparam int unsigned IdxW = $clog2(NCyc + 1);
  localparam logic [IdxW-1:0] LastCnt = IdxW'(NCyc - 1);

  if ((RPC == 0) || ((NR % RPC) != 0)) begin : g_bad_rpc
    $error("aes_dec_seq: RPC must divide NR (legal values 1, 2, 5, 10)");
  end

  typedef enum logic [0:0] {StIdle, StRun} fsm_e;

  fsm_e            fsm_q;
  logic [127:0]    state_q;
  logic [IdxW-1:0] cnt_q;
  logic [127:0]    chain_res;
  logic            abort_hit;

`ifdef AES_DEC_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers, AES polynomial x^8 + x^4 + x^3 + x + 1
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  // Inverse affine transform followed by field inversion
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // ---------------------------------------------------------------------------
  // Round transforms. Byte i of the state sits at bits [127-8*i -: 8];
  // byte i is row (i % 4), column (i / 4).
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                 input logic [127:0] k);
    return s ^ k;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Row r rotates right by r columns
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c+0) -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c+0) -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                              gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[127-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                              gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[127-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                              gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[127-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                              gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // One inverse sub-round; the very first one (global j == 0) skips InvMixColumns
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic         mix);
    logic [127:0] t;
    t = add_round_key(s, k);
    if (mix) t = inv_mix_columns(t);
    return inv_sub_bytes(inv_shift_rows(t));
  endfunction

  // Chain the RPC sub-rounds of the current cycle combinationally
  always_comb begin : p_chain
    logic [127:0] acc;
    acc = state_q;
    for (int k = 0; k < int'(RPC); k++) begin
      acc = inv_round(acc, rk_in[128*k +: 128], (cnt_q != '0) || (k != 0));
    end
    chain_res = acc;
  end

  // cnt_q is kept at zero outside RUN, so it doubles as the key index
  assign rk_idx = cnt_q;

  // Control FSM with registered busy/done/pt_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pt_out  <= '0;
    end else begin
      done <= 1'b0;
      case (fsm_q)
        StIdle: begin
          if (start) begin
            state_q <= ct_in;
            cnt_q   <= '0;
            busy    <= 1'b1;
            fsm_q   <= StRun;
          end
        end
        StRun: begin
          if (abort_hit) begin
            cnt_q <= '0;
            busy  <= 1'b0;
            fsm_q <= StIdle;
          end else if (cnt_q == LastCnt) begin
            pt_out <= chain_res ^ rk_final;
            done   <= 1'b1;
            cnt_q  <= '0;
            busy   <= 1'b0;
            fsm_q  <= StIdle;
          end else begin
            state_q <= chain_res;
            cnt_q   <= cnt_q + IdxW'(1);
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_seq.sv
// Bench for aes_dec_seq: four instances (RPC = 2, 1, 5, 10) share the stimulus.
// Round keys are expanded here from the cipher key and supplied per instance
// from its rk_idx. Hand sequences exercise the RPC=2 instance (index 0).
module tb_aes_dec_seq;

  localparam int unsigned NR = 10;
  localparam int NINST = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] ct_in = '0;
  logic [127:0] rk_final = '0;
`ifdef AES_DEC_ABORT_EN
  logic         abort = 1'b0;
`endif

  logic [127:0]     rk [11];
  logic [NINST-1:0] busy_v;
  logic [NINST-1:0] done_v;
  logic [127:0]     pt_v [NINST];
  logic [3:0]       idx_v [NINST];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  function automatic int rpc_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      2:       return 5;
      default: return 10;
    endcase
  endfunction

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    localparam int unsigned R  = rpc_of(g);
    localparam int unsigned IW = $clog2(NR / R + 1);
    logic [128*R-1:0] rk_in_g;
    logic [IW-1:0]    idx_g;
    logic [127:0]     pt_g;
    logic             busy_g;
    logic             done_g;

    // Key supplier: slice k carries K[NR - c*RPC - k]
    always_comb begin : p_keys
      int j;
      rk_in_g = '0;
      for (int k = 0; k < int'(R); k++) begin
        j = int'(NR) - int'(idx_g) * int'(R) - k;
        if (j >= 0 && j <= 10) rk_in_g[128*k +: 128] = rk[j[3:0]];
      end
    end

    aes_dec_seq #(.RPC(R)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
`ifdef AES_DEC_ABORT_EN
      .abort    (abort),
`endif
      .ct_in    (ct_in),
      .rk_in    (rk_in_g),
      .rk_final (rk_final),
      .rk_idx   (idx_g),
      .busy     (busy_g),
      .done     (done_g),
      .pt_out   (pt_g)
    );

    assign busy_v[g] = busy_g;
    assign done_v[g] = done_g;
    assign pt_v[g]   = pt_g;
    assign idx_v[g]  = 4'(idx_g);
  end

  // ---------------------------------------------------------------------------
  // Reference key expansion
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    logic [7:0] bb;
    r = 8'h00;
    aa = a;
    bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) r = r ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
        {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load(input vec_t v);
    expand_key(v.key);
    ct_in    = v.ct;
    rk_final = rk[0];
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Pulse start on instance 0 and wait (bounded) for its done pulse
  task automatic op0(output int lat, output logic [127:0] pt);
    lat = -1;
    pt  = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (n > 0) @(negedge clk);
      if (done_v[0]) begin
        lat = n;
        pt  = pt_v[0];
        break;
      end
    end
  endtask

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : p_main
    int           done_at  [NINST];
    int           done_cnt [NINST];
    int           busy_cnt [NINST];
    int           idx_bad  [NINST];
    int           lat;
    int           first;
    int           second;
    int           dcount;
    logic [127:0] pt;
    logic [127:0] last_pt;

    vecs[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[2] = '{128'hf5d3d58503b9699de785895a96fdbaaf, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'hae2d8a571e03ac9c9eb76fac45af8e51};
    vecs[3] = '{128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734};
    expand_key(128'h0);

    // Reset state
    repeat (2) @(negedge clk);
    for (int g = 0; g < NINST; g++) begin
      chk_int($sformatf("rst_busy[%0d]", g), int'(busy_v[g]), 0);
      chk_int($sformatf("rst_done[%0d]", g), int'(done_v[g]), 0);
      chk_int($sformatf("rst_idx[%0d]", g), int'(idx_v[g]), 0);
      chk($sformatf("rst_pt[%0d]", g), pt_v[g], 128'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Table: every vector through every RPC build
    for (int v = 0; v < 4; v++) begin
      load(vecs[v]);
      for (int g = 0; g < NINST; g++) begin
        done_at[g] = -1; done_cnt[g] = 0; busy_cnt[g] = 0; idx_bad[g] = 0;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 14; n++) begin
        if (n > 0) @(negedge clk);
        for (int g = 0; g < NINST; g++) begin
          if (busy_v[g]) begin
            busy_cnt[g]++;
            if (int'(idx_v[g]) != n) idx_bad[g]++;
          end
          if (done_v[g]) begin
            done_cnt[g]++;
            if (done_at[g] < 0) done_at[g] = n;
          end
        end
      end
      for (int g = 0; g < NINST; g++) begin
        chk($sformatf("v%0d_rpc%0d_pt", v, rpc_of(g)), pt_v[g], vecs[v].pt);
        chk_int($sformatf("v%0d_rpc%0d_latency", v, rpc_of(g)), done_at[g],
                int'(NR) / rpc_of(g));
        chk_int($sformatf("v%0d_rpc%0d_done_pulses", v, rpc_of(g)), done_cnt[g], 1);
        chk_int($sformatf("v%0d_rpc%0d_busy_clocks", v, rpc_of(g)), busy_cnt[g],
                int'(NR) / rpc_of(g));
        chk_int($sformatf("v%0d_rpc%0d_idx_steps_bad", v, rpc_of(g)), idx_bad[g], 0);
      end
    end

    // start pulsed during RUN cycles 1 and 3 is ignored
    load(vecs[0]);
    done_at[0] = -1; done_cnt[0] = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 14; n++) begin
      if (n > 0) @(negedge clk);
      if (done_v[0]) begin
        done_cnt[0]++;
        if (done_at[0] < 0) done_at[0] = n;
      end
      start = (n == 1 || n == 3);
    end
    start = 1'b0;
    chk_int("busy_start_done_pulses", done_cnt[0], 1);
    chk_int("busy_start_latency", done_at[0], 5);
    chk("busy_start_pt", pt_v[0], vecs[0].pt);
    repeat (12) @(negedge clk);

    // Back-to-back: second start in the done cycle
    load(vecs[0]);
    first = -1; second = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (n > 0) @(negedge clk);
      start = 1'b0;
      if (done_v[0]) begin
        if (first < 0) begin
          first = n;
          chk("b2b_first_pt", pt_v[0], vecs[0].pt);
          load(vecs[1]);
          start = 1'b1;
        end else if (second < 0) begin
          second = n;
          chk("b2b_second_pt", pt_v[0], vecs[1].pt);
        end
      end
    end
    start = 1'b0;
    chk_int("b2b_first_latency", first, 5);
    chk_int("b2b_spacing", (second < 0) ? -1 : second - first, 6);
    repeat (12) @(negedge clk);

    // Reset during RUN cycle 2
    load(vecs[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_int("midrst_busy", int'(busy_v[0]), 0);
    chk_int("midrst_idx", int'(idx_v[0]), 0);
    chk("midrst_pt", pt_v[0], 128'h0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) dcount++;
    end
    chk_int("midrst_no_done", dcount, 0);
    load(vecs[1]);
    op0(lat, pt);
    chk_int("postrst_latency", lat, 5);
    chk("postrst_pt", pt, vecs[1].pt);
    last_pt = vecs[1].pt;
    repeat (12) @(negedge clk);

`ifdef AES_DEC_ABORT_EN
    // Abort at RUN cycle 3
    load(vecs[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_int("abort_mid_busy", int'(busy_v[0]), 0);
    chk_int("abort_mid_done", int'(done_v[0]), 0);
    chk("abort_mid_pt", pt_v[0], last_pt);
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_v[0]) dcount++;
    end
    chk_int("abort_mid_no_done", dcount, 0);
    repeat (4) @(negedge clk);

    // Abort coinciding with the last RUN edge
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_int("abort_last_done", int'(done_v[0]), 0);
    chk_int("abort_last_busy", int'(busy_v[0]), 0);
    chk("abort_last_pt", pt_v[0], last_pt);
    repeat (12) @(negedge clk);

    // Abort in IDLE with a simultaneous start: start still accepted
    load(vecs[2]);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk_int("abort_idle_busy", int'(busy_v[0]), 1);
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      if (n > 0) @(negedge clk);
      if (done_v[0]) begin
        lat = n;
        break;
      end
    end
    chk_int("abort_idle_latency", lat, 5);
    chk("abort_idle_pt", pt_v[0], vecs[2].pt);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
